// File: rtl/scr1_pulp_mem_arb_if.sv
// PULP-style data port bundle: req/gnt address phase, rvalid response phase.
// The master drives the request; the slave grants it and returns in-order responses.
interface scr1_pulp_mem_arb_if #(
  parameter int AW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic          we;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;

  modport master (output req, addr, be, we, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, be, we, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/scr1_pulp_mem_arb.sv
// Two-master round-robin arbiter onto one PULP data port. An ID FIFO records the issuer
// of each granted transaction so that in-order responses can be routed back to it.
module scr1_pulp_mem_arb #(
  parameter int SCR1_ADDR_WIDTH = 32,
  parameter int OUTSTD          = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scr1_pulp_mem_arb_if.slave   m0,
  scr1_pulp_mem_arb_if.slave   m1,
  scr1_pulp_mem_arb_if.master  data,
  output logic                 proto_err_o
);

  typedef struct packed {
    logic [SCR1_ADDR_WIDTH-1:0] addr;
    logic [3:0]                 be;
    logic                       we;
    logic [31:0]                wdata;
  } mem_req_t;

  localparam logic [2:0] OUTSTD_C = 3'(OUTSTD);
  localparam logic [1:0] PTR_LAST = 2'(OUTSTD - 1);

  mem_req_t   mreq [2];
  mem_req_t   sel_req;
  logic       sel, sel_q, lock, rr_ptr;
  logic       sel_vld, space, hs, pop, head;
  logic [2:0] count;
  logic [1:0] wr_ptr, rd_ptr;
  logic [3:0] id_fifo;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign mreq[0] = {m0.addr, m0.be, m0.we, m0.wdata};
  assign mreq[1] = {m1.addr, m1.be, m1.we, m1.wdata};

  // A locked (pending, ungranted) request keeps its master regardless of the other requester.
  always_comb begin
    sel = sel_q;
    if (!lock) begin
      if (m0.req && m1.req) sel = rr_ptr;
      else                  sel = m1.req;
    end
  end

  assign sel_req = sel ? mreq[1] : mreq[0];
  assign sel_vld = sel ? m1.req : m0.req;

  // A response popping in this cycle frees its slot for a same-cycle grant.
  assign pop   = data.rvalid & (count != 3'd0);
  assign space = (count < OUTSTD_C) | pop;

  assign data.req   = rst_n & sel_vld & space;
  assign data.addr  = sel_req.addr;
  assign data.be    = sel_req.be;
  assign data.we    = sel_req.we;
  assign data.wdata = sel_req.wdata;

  assign hs     = data.req & data.gnt;
  assign m0.gnt = hs & ~sel;
  assign m1.gnt = hs & sel;

  assign head      = id_fifo[rd_ptr];
  assign m0.rvalid = rst_n & pop & ~head;
  assign m1.rvalid = rst_n & pop & head;
  assign m0.err    = pop & ~head & data.err;
  assign m1.err    = pop & head & data.err;
  assign m0.rdata  = data.rdata;
  assign m1.rdata  = data.rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 3'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      id_fifo     <= 4'd0;
      rr_ptr      <= 1'b1;
      lock        <= 1'b0;
      sel_q       <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      lock  <= data.req & ~data.gnt;
      sel_q <= sel;
      if (hs) begin
        rr_ptr          <= ~sel;
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({hs, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (data.rvalid && count == 3'd0) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scr1_pulp_mem_arb.sv
// Directed bench for the two-master PULP arbiter: arbitration order, lock, outstanding
// limit, response routing with error, and the sticky protocol-error flag.
module tb_scr1_pulp_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic proto_err;
  int   checks = 0;
  int   errors = 0;

  scr1_pulp_mem_arb_if #(.AW(32)) m0_if ();
  scr1_pulp_mem_arb_if #(.AW(32)) m1_if ();
  scr1_pulp_mem_arb_if #(.AW(32)) data_if ();

  scr1_pulp_mem_arb #(.SCR1_ADDR_WIDTH(32), .OUTSTD(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .data        (data_if),
    .proto_err_o (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_if.req = 0; m0_if.addr = 0; m0_if.be = 4'hF; m0_if.we = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.addr = 0; m1_if.be = 4'hF; m1_if.we = 0; m1_if.wdata = 0;
    data_if.gnt = 0; data_if.rvalid = 0; data_if.rdata = 0; data_if.err = 0;

    // reset: outputs forced low even with a request and a grant present
    m0_if.req = 1; data_if.gnt = 1;
    #2;
    chk("rst_data_req", data_if.req, 0);
    chk("rst_m0_gnt", m0_if.gnt, 0);
    chk("rst_proto_err", proto_err, 0);
    step();
    rst_n = 1;

    // 1: single m0 read, response next cycle
    m0_if.addr = 32'h100; m0_if.req = 1; data_if.gnt = 1;
    #1;
    chk("t1_data_req", data_if.req, 1);
    chk("t1_addr", data_if.addr, 32'h100);
    chk("t1_m0_gnt", m0_if.gnt, 1);
    chk("t1_m1_gnt", m1_if.gnt, 0);
    step();
    m0_if.req = 0; data_if.gnt = 0; data_if.rvalid = 1; data_if.rdata = 32'hDEADBEEF;
    #1;
    chk("t1_m0_rvalid", m0_if.rvalid, 1);
    chk("t1_m1_rvalid", m1_if.rvalid, 0);
    chk("t1_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
    step();
    data_if.rvalid = 0;

    // 2: both request, gnt always 1 -> m1,m0,m1,m0; responses drain the previous grant
    m0_if.req = 1; m0_if.addr = 32'h200;
    m1_if.req = 1; m1_if.addr = 32'h300;
    data_if.gnt = 1;
    for (int i = 0; i < 4; i++) begin
      data_if.rvalid = (i > 0);
      #1;
      chk($sformatf("t2_m1_gnt%0d", i), m1_if.gnt, (i % 2 == 0));
      chk($sformatf("t2_m0_gnt%0d", i), m0_if.gnt, (i % 2 == 1));
      chk($sformatf("t2_addr%0d", i), data_if.addr, (i % 2 == 0) ? 32'h300 : 32'h200);
      if (i > 0) chk($sformatf("t2_m1_rvalid%0d", i), m1_if.rvalid, (i % 2 == 1));
      step();
    end
    m0_if.req = 0; m1_if.req = 0; data_if.gnt = 0; data_if.rvalid = 1;
    #1;
    chk("t2_drain_m0_rvalid", m0_if.rvalid, 1);
    step();
    data_if.rvalid = 0;

    // 3: m0 pending ungranted stays locked although m1 (preferred by rr) requests
    m0_if.req = 1; m0_if.addr = 32'h400;
    #1;
    chk("t3_c1_addr", data_if.addr, 32'h400);
    step();
    m1_if.req = 1; m1_if.addr = 32'h500;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t3_lock_addr%0d", i), data_if.addr, 32'h400);
      chk($sformatf("t3_lock_req%0d", i), data_if.req, 1);
      step();
    end
    data_if.gnt = 1;
    #1;
    chk("t3_m0_gnt", m0_if.gnt, 1);
    chk("t3_m1_gnt_no", m1_if.gnt, 0);
    step();
    m0_if.req = 0; data_if.rvalid = 1;
    #1;
    chk("t3_m1_gnt", m1_if.gnt, 1);
    chk("t3_m1_addr", data_if.addr, 32'h500);
    chk("t3_m0_rvalid", m0_if.rvalid, 1);
    step();
    m1_if.req = 0; data_if.gnt = 0;
    #1;
    chk("t3_m1_rvalid", m1_if.rvalid, 1);
    step();
    data_if.rvalid = 0;

    // 4: outstanding limit of 2, then a same-cycle pop frees a slot
    m0_if.req = 1; m0_if.addr = 32'h600; data_if.gnt = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t4_gnt%0d", i), m0_if.gnt, 1);
      step();
    end
    #1;
    chk("t4_full_req", data_if.req, 0);
    chk("t4_full_gnt", m0_if.gnt, 0);
    step();
    data_if.rvalid = 1;
    #1;
    chk("t4_pop_req", data_if.req, 1);
    chk("t4_pop_gnt", m0_if.gnt, 1);
    chk("t4_pop_rvalid", m0_if.rvalid, 1);
    step();
    data_if.rvalid = 0;
    #1;
    chk("t4_still_full", data_if.req, 0);
    step();
    m0_if.req = 0; data_if.gnt = 0; data_if.rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t4_drain%0d", i), m0_if.rvalid, 1);
      step();
    end
    data_if.rvalid = 0;

    // 5: issue m1,m0,m1; responses m1, m0 with err, m1
    data_if.gnt = 1;
    m1_if.req = 1; m1_if.addr = 32'h700;
    #1;
    chk("t5_g1_m1", m1_if.gnt, 1);
    step();
    m1_if.req = 0; m0_if.req = 1; m0_if.addr = 32'h704;
    #1;
    chk("t5_g2_m0", m0_if.gnt, 1);
    step();
    m0_if.req = 0; m1_if.req = 1; m1_if.addr = 32'h708; data_if.rvalid = 1; data_if.err = 0;
    #1;
    chk("t5_g3_m1", m1_if.gnt, 1);
    chk("t5_r1_m1", m1_if.rvalid, 1);
    chk("t5_r1_m0", m0_if.rvalid, 0);
    step();
    m1_if.req = 0; data_if.gnt = 0; data_if.err = 1;
    #1;
    chk("t5_r2_m0", m0_if.rvalid, 1);
    chk("t5_r2_m0_err", m0_if.err, 1);
    chk("t5_r2_m1", m1_if.rvalid, 0);
    chk("t5_r2_m1_err", m1_if.err, 0);
    step();
    data_if.err = 0;
    #1;
    chk("t5_r3_m1", m1_if.rvalid, 1);
    chk("t5_r3_m1_err", m1_if.err, 0);
    step();
    data_if.rvalid = 0;

    // 6: rvalid with empty FIFO sets sticky proto_err; reset clears it
    #1;
    chk("t6_pre", proto_err, 0);
    data_if.rvalid = 1;
    #1;
    chk("t6_m0_rvalid", m0_if.rvalid, 0);
    chk("t6_m1_rvalid", m1_if.rvalid, 0);
    step();
    data_if.rvalid = 0;
    chk("t6_set", proto_err, 1);
    step();
    step();
    chk("t6_sticky", proto_err, 1);
    rst_n = 0;
    #1;
    chk("t6_cleared", proto_err, 0);
    step();
    rst_n = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
